pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and branch/jump redirects, and runs a req/ack handshake FSM that freezes the pipeline while data memory is busy. It also keeps a stall-cycle performance counter and a sticky memory-timeout error flag.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush/bubble sequencer for the 5-stage pipeline
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RTaddr_i,
    input  logic [4:0]       IFID_RSaddr_i,
    input  logic [4:0]       IFID_RTaddr_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             EXMEM_MemAcc_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_hold_o,
    output logic             MEMWB_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [TO_W-1:0]  c_timeout = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wcnt_q,  wcnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_q,   err_d;

    logic              w_luh;
    logic              w_redir;
    logic              w_freeze;
    logic              w_req;

    assign w_luh = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                   ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));
    assign w_redir = branch_taken_i | jump_i;

    // Memory handshake FSM: decides freeze and the next wait-counter value.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        w_freeze = 1'b0;
        w_req    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                w_req = EXMEM_MemAcc_i;
                if (EXMEM_MemAcc_i && !dmem_ack_i) begin
                    w_freeze = 1'b1;
                    state_d  = S_WAIT;
                    wcnt_d   = TO_W'(1);
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (dmem_ack_i) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == c_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else begin
                    w_freeze = 1'b1;
                    wcnt_d   = wcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Pipeline-register controls, highest priority first; reset forces a
    // safe NOP-injecting pattern regardless of state.
    always_comb begin
        dmem_req_o     = w_req;
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        EXMEM_hold_o   = 1'b0;
        MEMWB_bubble_o = 1'b0;
        if (!rst_i) begin
            dmem_req_o     = 1'b0;
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IFID_flush_o   = 1'b1;
            IDEX_bubble_o  = 1'b1;
            EXMEM_hold_o   = 1'b0;
            MEMWB_bubble_o = 1'b1;
        end else if (w_freeze) begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            EXMEM_hold_o   = 1'b1;
            MEMWB_bubble_o = 1'b1;
        end else if (w_luh) begin
            // Branch in ID re-resolves next cycle once the load data is ready.
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_bubble_o  = 1'b1;
        end else if (w_redir) begin
            IFID_flush_o   = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!PC_write_o && (stall_q != c_cnt_max)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed scoreboard bench for pipe_hazard_ctrl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    // {req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}
    localparam logic [6:0] c_nrm = 7'b0110000;
    localparam logic [6:0] c_luh = 7'b0000100;
    localparam logic [6:0] c_rdr = 7'b0111000;
    localparam logic [6:0] c_frz = 7'b1000011;
    localparam logic [6:0] c_rst = 7'b0001101;
    localparam logic [6:0] c_rel = 7'b1110000;
    localparam logic [6:0] c_rlb = 7'b1111000;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mr;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        br;
    logic        jmp;
    logic        macc;
    logic        ack;
    logic        req;
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        bub;
    logic        hold;
    logic        mwb;
    logic [15:0] scnt;
    logic        err;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_errors;
    logic [15:0] exp_stall;
    logic        exp_err;
    int          vec_id;

    pipe_hazard_ctrl #(
        .TIMEOUT (4),
        .TO_W    (7),
        .CNT_W   (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .IDEX_MemRead_i (mr),
        .IDEX_RTaddr_i  (ex_rt),
        .IFID_RSaddr_i  (id_rs),
        .IFID_RTaddr_i  (id_rt),
        .branch_taken_i (br),
        .jump_i         (jmp),
        .EXMEM_MemAcc_i (macc),
        .dmem_ack_i     (ack),
        .dmem_req_o     (req),
        .PC_write_o     (pcw),
        .IFID_write_o   (ifw),
        .IFID_flush_o   (flush),
        .IDEX_bubble_o  (bub),
        .EXMEM_hold_o   (hold),
        .MEMWB_bubble_o (mwb),
        .stall_cnt_o    (scnt),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected vector per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        exp_t a;
        int   idx;
        idx = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a.ctl = {req, pcw, ifw, flush, bub, hold, mwb};
                a.cnt = scnt;
                a.err = err;
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL vec%0d: ctl=%b cnt=%0d err=%b, required ctl=%b cnt=%0d err=%b",
                             idx, a.ctl, a.cnt, a.err, e.ctl, e.cnt, e.err);
                end
                idx++;
            end
        end
    end

    // Drive one cycle of inputs and queue the hand-computed response.
    task automatic step(input logic r, input logic i_mr, input logic [4:0] i_ext,
                        input logic [4:0] i_rs, input logic [4:0] i_rt,
                        input logic i_br, input logic i_jmp, input logic i_macc,
                        input logic i_ack, input logic [6:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        mr    = i_mr;
        ex_rt = i_ext;
        id_rs = i_rs;
        id_rt = i_rt;
        br    = i_br;
        jmp   = i_jmp;
        macc  = i_macc;
        ack   = i_ack;
        if (!r) begin
            exp_stall = '0;
            exp_err   = 1'b0;
        end
        e.ctl = ctl;
        e.cnt = exp_stall;
        e.err = exp_err;
        sb_q.push_back(e);
        vec_id++;
        if (r && !ctl[5]) exp_stall = exp_stall + 16'd1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = '0;
        exp_err   = 1'b0;
        vec_id    = 0;
        rst_n = 1'b0; mr = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        br = 1'b0; jmp = 1'b0; macc = 1'b0; ack = 1'b0;

        // reset, then quiet pipeline
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, c_rst);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        // load-use on rs, then on rt; register 0 never stalls
        step(1, 1, 8, 8, 3, 0, 0, 0, 0, c_luh);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        step(1, 1, 5, 1, 5, 0, 0, 0, 0, c_luh);
        step(1, 1, 5, 1, 2, 0, 0, 0, 0, c_nrm);
        // redirects, and luh suppressing a taken branch
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, c_rdr);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, c_rdr);
        step(1, 1, 9, 9, 0, 1, 0, 0, 0, c_luh);
        // memory wait: 3 frozen cycles then ack; luh ignored while frozen
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 1, 7, 7, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 1, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, c_rel);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        // ack in the first cycle, stray ack without access
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, c_rel);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, c_nrm);
        // release cycle carrying a taken branch
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 1, 0, 1, 1, c_rlb);
        // timeout: 4 frozen cycles, release on the 5th, err from the next
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_rel);
        exp_err = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        step(1, 1, 4, 4, 0, 0, 0, 0, 0, c_luh);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);
        // reset in WAIT, then a fresh access
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, c_rst);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, c_frz);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, c_rel);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, c_nrm);

        // drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
